// File: rtl/neureka_outfeat_packer.sv
// neureka_outfeat_packer
// Takes the serialized engine store stream for one tile (NR_PE beats). Beats
// from masked-off PEs are consumed and dropped. Kept beats have their byte
// strobe trimmed to the first k_rem bytes and go through a 2-entry skid
// buffer. The buffer head register drives pop_*.
// Optional feature: define NEUREKA_PACKER_PERF_EN to add stall_cnt_o, a
// saturating count of cycles where pop_valid_o=1 and pop_ready_i=0.
module neureka_outfeat_packer #(
    parameter int NR_PE = 9,
    parameter int DW    = 256
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             start_i,
    input  logic [NR_PE-1:0] pe_mask_i,
    input  logic [5:0]       k_rem_i,
    input  logic             push_valid_i,
    output logic             push_ready_o,
    input  logic [DW-1:0]    push_data_i,
    input  logic [DW/8-1:0]  push_strb_i,
    output logic             pop_valid_o,
    input  logic             pop_ready_i,
    output logic [DW-1:0]    pop_data_o,
    output logic [DW/8-1:0]  pop_strb_o,
    output logic             busy_o,
`ifdef NEUREKA_PACKER_PERF_EN
    output logic             done_o,
    output logic [31:0]      stall_cnt_o
`else
    output logic             done_o
`endif
);
    localparam int NB = DW / 8;
    localparam int CW = (NR_PE > 1) ? $clog2(NR_PE) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    pe_cnt_q, pe_cnt_d;
    logic [NR_PE-1:0] mask_q;
    logic [5:0]       krem_q;
    logic [1:0]       cnt_q, cnt_d;
    logic [DW-1:0]    dat0_q, dat0_d, dat1_q, dat1_d;
    logic [NB-1:0]    strb0_q, strb0_d, strb1_q, strb1_d;
    logic             done_q, done_d;
    logic             start_acc, push_fire, keep_fire, pop_fire;
    logic             last_beat, cur_keep;
    logic [NB-1:0]    strb_in;

    // Byte mask with the lowest k bytes set; k=0 or k beyond the beat width
    // selects every byte.
    function automatic logic [NB-1:0] byte_mask(input logic [5:0] k);
        logic [NB-1:0] m;
        for (int i = 0; i < NB; i++) begin
            m[i] = (k == 6'd0) || (i < int'(k));
        end
        return m;
    endfunction

    assign start_acc   = (state_q == IDLE) && start_i && !clear_i;
    assign cur_keep    = mask_q[pe_cnt_q];
    assign last_beat   = (pe_cnt_q == CW'(NR_PE - 1));
    assign push_fire   = push_valid_i && push_ready_o;
    assign keep_fire   = push_fire && cur_keep;
    assign pop_valid_o = (cnt_q != 2'd0);
    assign pop_fire    = pop_valid_o && pop_ready_i;
    assign pop_data_o  = dat0_q;
    assign pop_strb_o  = strb0_q;
    assign strb_in     = push_strb_i & byte_mask(krem_q);
    assign done_o      = done_q;

    // FSM state register
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next state; DRAIN exits once the buffer will be empty next cycle
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (push_fire && last_beat) state_d = DRAIN;
            DRAIN:   if (cnt_d == 2'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (clear_i) state_d = IDLE;
    end

    // FSM outputs: dropped beats never stall, kept beats wait for buffer space
    always_comb begin
        push_ready_o = 1'b0;
        if (state_q == RUN) push_ready_o = !cur_keep || (cnt_q != 2'd2);
        busy_o = (state_q != IDLE);
        done_d = (state_q == DRAIN) && (cnt_d == 2'd0) && !clear_i;
    end

    // PE beat counter next state
    always_comb begin
        pe_cnt_d = pe_cnt_q;
        if (clear_i || start_acc) pe_cnt_d = '0;
        else if (push_fire)       pe_cnt_d = last_beat ? '0 : pe_cnt_q + CW'(1);
    end

    // Skid buffer next state; entry 0 is always the head shown on pop_*
    always_comb begin
        cnt_d   = cnt_q;
        dat0_d  = dat0_q;
        strb0_d = strb0_q;
        dat1_d  = dat1_q;
        strb1_d = strb1_q;
        if (clear_i) begin
            cnt_d = 2'd0;
        end else begin
            case ({keep_fire, pop_fire})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        dat0_d  = push_data_i;
                        strb0_d = strb_in;
                    end else begin
                        dat1_d  = push_data_i;
                        strb1_d = strb_in;
                    end
                    cnt_d = cnt_q + 2'd1;
                end
                2'b01: begin
                    dat0_d  = dat1_q;
                    strb0_d = strb1_q;
                    cnt_d   = cnt_q - 2'd1;
                end
                2'b11: begin
                    if (cnt_q == 2'd1) begin
                        dat0_d  = push_data_i;
                        strb0_d = strb_in;
                    end else begin
                        dat0_d  = dat1_q;
                        strb0_d = strb1_q;
                        dat1_d  = push_data_i;
                        strb1_d = strb_in;
                    end
                end
                default: ;
            endcase
        end
    end

    // Control registers: beat counter, tile configuration, occupancy, done pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pe_cnt_q <= '0;
            mask_q   <= '0;
            krem_q   <= '0;
            cnt_q    <= 2'd0;
            done_q   <= 1'b0;
        end else begin
            pe_cnt_q <= pe_cnt_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            if (start_acc) begin
                mask_q <= pe_mask_i;
                krem_q <= k_rem_i;
            end
        end
    end

    // Buffer payload registers; zeroed on reset so pop_* starts clean
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dat0_q  <= '0;
            strb0_q <= '0;
            dat1_q  <= '0;
            strb1_q <= '0;
        end else begin
            dat0_q  <= dat0_d;
            strb0_q <= strb0_d;
            dat1_q  <= dat1_d;
            strb1_q <= strb1_d;
        end
    end

`ifdef NEUREKA_PACKER_PERF_EN
    logic [31:0] stall_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Backpressure stall counter, restarted per tile
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                          stall_q <= '0;
        else if (clear_i || start_acc)      stall_q <= '0;
        else if (pop_valid_o && !pop_ready_i) stall_q <= sat_inc(stall_q);
    end

    assign stall_cnt_o = stall_q;
`endif

endmodule

// File: tb/tb_neureka_outfeat_packer.sv
// Scoreboard bench for neureka_outfeat_packer: the driver pushes the expected
// packed beat at acceptance, a negedge monitor pops and compares.
module tb_neureka_outfeat_packer;
    localparam int NR_PE = 9;
    localparam int DW    = 256;

    logic             clk = 1'b0;
    logic             rst_i, clear_i, start_i;
    logic [NR_PE-1:0] pe_mask_i;
    logic [5:0]       k_rem_i;
    logic             push_valid_i, push_ready_o;
    logic [DW-1:0]    push_data_i;
    logic [DW/8-1:0]  push_strb_i;
    logic             pop_valid_o, pop_ready_i;
    logic [DW-1:0]    pop_data_o;
    logic [DW/8-1:0]  pop_strb_o;
    logic             busy_o, done_o;
`ifdef NEUREKA_PACKER_PERF_EN
    logic [31:0]      stall_cnt_o;
`endif

    neureka_outfeat_packer #(.NR_PE(NR_PE), .DW(DW)) dut (
        .clk_i(clk), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
        .pe_mask_i(pe_mask_i), .k_rem_i(k_rem_i),
        .push_valid_i(push_valid_i), .push_ready_o(push_ready_o),
        .push_data_i(push_data_i), .push_strb_i(push_strb_i),
        .pop_valid_o(pop_valid_o), .pop_ready_i(pop_ready_i),
        .pop_data_o(pop_data_o), .pop_strb_o(pop_strb_o),
        .busy_o(busy_o),
`ifdef NEUREKA_PACKER_PERF_EN
        .done_o(done_o),
        .stall_cnt_o(stall_cnt_o)
`else
        .done_o(done_o)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [255:0] d;
        logic [31:0]  s;
        int           acc;
    } ent_t;

    ent_t         exp_q[$];
    ent_t         me;
    int           n_chk = 0, n_fail = 0;
    int           cyc = 0, done_cnt = 0, done_cyc = 0, n_pops = 0;
    bit           chk_lat = 0, bp_rand = 0, strb_ones = 1, pr_force = 1, rnd_rdy = 1;
    bit           hold_v = 0;
    logic [255:0] hold_d, hd;
    logic [31:0]  hold_s;
    int           acc_s, dc_s, pc_s, nw;

    assign pop_ready_i = bp_rand ? rnd_rdy : pr_force;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        rnd_rdy = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] req);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, req);
        end
    endtask

    function automatic logic [31:0] kmask_model(input logic [5:0] k);
        int          kb;
        logic [32:0] t;
        kb = (k == 6'd0 || k >= 6'd32) ? 32 : int'(k);
        t  = (33'd1 << kb) - 33'd1;
        return t[31:0];
    endfunction

    // Monitor: stability under backpressure, in-order payload, latency, done pulses
    always @(negedge clk) begin
        if (rst_i || clear_i) begin
            hold_v = 0;
        end else begin
            if (hold_v && pop_valid_o)
                chk(pop_data_o == hold_d && pop_strb_o == hold_s, "pop_stable", pop_data_o, hold_d);
            if (pop_valid_o && pop_ready_i) begin
                n_pops++;
                if (exp_q.size() == 0) begin
                    chk(1'b0, "pop_unexpected", pop_data_o, 256'(0));
                end else begin
                    me = exp_q.pop_front();
                    chk(pop_data_o == me.d, "pop_data", pop_data_o, me.d);
                    chk(pop_strb_o == me.s, "pop_strb", 256'(pop_strb_o), 256'(me.s));
                    if (chk_lat) chk(cyc == me.acc + 1, "pop_latency", 256'(cyc), 256'(me.acc + 1));
                end
            end
            hold_v = pop_valid_o && !pop_ready_i;
            hold_d = pop_data_o;
            hold_s = pop_strb_o;
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic do_start(input logic [8:0] m, input logic [5:0] k);
        pe_mask_i = m;
        k_rem_i   = k;
        start_i   = 1'b1;
        @(posedge clk); #1;
        start_i   = 1'b0;
        pe_mask_i = 9'($urandom);
        k_rem_i   = 6'($urandom);
    endtask

    task automatic send_beat(input int p, input logic [8:0] m, input logic [5:0] k, input bit gaps, output int acc);
        logic [255:0] d;
        logic [31:0]  s;
        ent_t         e;
        int           n;
        bit           got;
        for (int w = 0; w < 8; w++) d[w*32 +: 32] = $urandom;
        s = strb_ones ? 32'hFFFF_FFFF : $urandom;
        push_valid_i = 1'b1;
        push_data_i  = d;
        push_strb_i  = s;
        start_i      = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
        n = 0;
        got = 0;
        while (!got && n < 100) begin
            @(negedge clk);
            if (push_ready_o) got = 1;
            else n++;
        end
        acc = cyc;
        if (!got) chk(1'b0, "push_timeout", 256'(n), 256'(100));
        if (!m[p]) chk(n == 0, "drop_nostall", 256'(n), 256'(0));
        if (got && m[p]) begin
            e.d = d;
            e.s = s & kmask_model(k);
            e.acc = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        push_valid_i = 1'b0;
        start_i      = 1'b0;
    endtask

    task automatic wait_done(input int dc0);
        int n;
        n = 0;
        while (done_cnt == dc0 && n < 400) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(done_cnt != dc0, "done_seen", 256'(done_cnt - dc0), 256'(1));
    endtask

    task automatic run_tile(input logic [8:0] m, input logic [5:0] k, input bit gaps, input bit timing);
        int dc0, pc0, acc;
        dc0 = done_cnt;
        pc0 = n_pops;
        chk_lat = timing;
        do_start(m, k);
        chk(busy_o == 1'b1, "busy_run", 256'(busy_o), 256'(1));
        for (int p = 0; p < NR_PE; p++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_beat(p, m, k, gaps, acc);
        end
        wait_done(dc0);
        if (timing) chk(done_cyc == acc + 2, "done_timing", 256'(done_cyc), 256'(acc + 2));
        chk(n_pops - pc0 == $countones(m), "pop_count", 256'(n_pops - pc0), 256'($countones(m)));
        chk(exp_q.size() == 0, "drained", 256'(exp_q.size()), 256'(0));
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == dc0 + 1, "done_once", 256'(done_cnt - dc0), 256'(1));
        chk(busy_o == 1'b0, "idle_after", 256'(busy_o), 256'(0));
        chk_lat = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        rst_i = 1'b1; clear_i = 1'b0; start_i = 1'b0;
        pe_mask_i = '0; k_rem_i = '0;
        push_valid_i = 1'b0; push_data_i = '0; push_strb_i = '0;
        #3;
        chk(pop_valid_o == 1'b0, "rst_pop_valid", 256'(pop_valid_o), 256'(0));
        chk(pop_data_o == '0, "rst_pop_data", pop_data_o, 256'(0));
        chk(pop_strb_o == '0, "rst_pop_strb", 256'(pop_strb_o), 256'(0));
        chk(push_ready_o == 1'b0, "rst_push_ready", 256'(push_ready_o), 256'(0));
        chk(busy_o == 1'b0 && done_o == 1'b0, "rst_busy_done", 256'({busy_o, done_o}), 256'(0));
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        @(posedge clk); #1;

        // full mask, all bytes, continuous pop
        run_tile(9'h1FF, 6'd0, 0, 1);
        // alternating mask
        run_tile(9'b101010101, 6'd0, 0, 1);
        // trimmed strobes
        run_tile(9'h1FF, 6'd5, 0, 1);

        // backpressure for 4 cycles mid-tile
        pr_force = 0;
        dc_s = done_cnt;
        do_start(9'h1FF, 6'd0);
        fork
            begin
                for (int p = 0; p < NR_PE; p++) send_beat(p, 9'h1FF, 6'd0, 0, acc_s);
            end
            begin
                nw = 0;
                do begin
                    @(negedge clk);
                    nw++;
                end while (!pop_valid_o && nw < 50);
                chk(pop_valid_o == 1'b1, "stall_popv", 256'(pop_valid_o), 256'(1));
                hd = pop_data_o;
                for (int i = 0; i < 4; i++) begin
                    if (i > 0) @(negedge clk);
                    chk(pop_data_o == hd, "stall_hold", pop_data_o, hd);
                    if (i == 3) chk(push_ready_o == 1'b0, "stall_push_ready", 256'(push_ready_o), 256'(0));
                end
                @(posedge clk); #1;
                pr_force = 1;
            end
        join
        wait_done(dc_s);
        chk(exp_q.size() == 0, "stall_drained", 256'(exp_q.size()), 256'(0));
`ifdef NEUREKA_PACKER_PERF_EN
        chk(stall_cnt_o == 32'd4, "stall_cnt", 256'(stall_cnt_o), 256'(4));
`endif
        repeat (2) @(posedge clk);
        #1;

        // clear after 3 accepted beats, start in the same cycle is ignored
        dc_s = done_cnt;
        do_start(9'h1FF, 6'd0);
        for (int p = 0; p < 3; p++) send_beat(p, 9'h1FF, 6'd0, 0, acc_s);
        clear_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        start_i = 1'b0;
        @(negedge clk);
        chk(pop_valid_o == 1'b0, "clear_pop_valid", 256'(pop_valid_o), 256'(0));
        chk(busy_o == 1'b0, "clear_idle", 256'(busy_o), 256'(0));
        repeat (5) @(negedge clk);
        chk(done_cnt == dc_s, "clear_no_done", 256'(done_cnt - dc_s), 256'(0));
        exp_q.delete();
        @(posedge clk); #1;
        clear_i = 1'b1;
        start_i = 1'b1;
        @(posedge clk); #1;
        clear_i = 1'b0;
        start_i = 1'b0;
        chk(busy_o == 1'b0, "clear_over_start", 256'(busy_o), 256'(0));
        run_tile(9'h1FF, 6'd0, 0, 1);
`ifdef NEUREKA_PACKER_PERF_EN
        chk(stall_cnt_o == 32'd0, "stall_restart", 256'(stall_cnt_o), 256'(0));
`endif

        // asynchronous reset mid-tile with a full buffer
        pr_force = 0;
        dc_s = done_cnt;
        do_start(9'h1FF, 6'd0);
        for (int p = 0; p < 2; p++) send_beat(p, 9'h1FF, 6'd0, 0, acc_s);
        #2;
        rst_i = 1'b1;
        #1;
        chk(pop_valid_o == 1'b0, "arst_pop_valid", 256'(pop_valid_o), 256'(0));
        chk(pop_data_o == '0, "arst_pop_data", pop_data_o, 256'(0));
        chk(pop_strb_o == '0, "arst_pop_strb", 256'(pop_strb_o), 256'(0));
        chk(push_ready_o == 1'b0, "arst_push_ready", 256'(push_ready_o), 256'(0));
        chk(busy_o == 1'b0 && done_o == 1'b0, "arst_busy_done", 256'({busy_o, done_o}), 256'(0));
        @(negedge clk);
        @(negedge clk);
        rst_i = 1'b0;
        exp_q.delete();
        pr_force = 1;
        repeat (4) @(posedge clk);
        #1;
        chk(done_cnt == dc_s, "arst_no_done", 256'(done_cnt - dc_s), 256'(0));

        // empty mask: every beat consumed, no pops, still done
        run_tile(9'h000, 6'd0, 0, 1);

        // randomized tiles with backpressure, gaps and random strobes
        strb_ones = 0;
        bp_rand = 1;
        for (int t = 0; t < 10; t++)
            run_tile(9'($urandom), 6'($urandom_range(0, 40)), 1, 0);
        bp_rand = 0;
        repeat (2) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/neureka_outfeat_packer.md
NEUREKA_OUTFEAT_PACKER -- requirements
Module: neureka_outfeat_packer

Interface
REQ-001 SHALL have parameter NR_PE, default 9, meaning the number of PE streamout beats per tile.
REQ-002 SHALL have parameter DW, default 256, meaning the data width in bits of each beat.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port rst_i, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port clear_i, input, 1, synchronous clear.
REQ-006 SHALL have port start_i, input, 1, single-cycle tile start pulse.
REQ-007 SHALL have port pe_mask_i, input, NR_PE, per-PE keep mask, sampled at start.
REQ-008 SHALL have port k_rem_i, input, 6, valid output bytes per beat (0 or ≥32 means all 32), sampled at start.
REQ-009 SHALL have port push_valid_i / push_ready_o, input / output, 1 each, handshake of the serialized engine store stream.
REQ-010 SHALL have port push_data_i / push_strb_i, input, DW / DW/8, data and byte strobe of the serialized engine store stream.
REQ-011 SHALL have port pop_valid_o / pop_ready_i, output / input, 1 each, handshake of the stream toward the streamer.
REQ-012 SHALL have port pop_data_o / pop_strb_o, output, DW / DW/8, data and byte strobe toward the streamer.
REQ-013 SHALL have port busy_o, output, 1, high in any state other than IDLE.
REQ-014 SHALL have port done_o, output, 1, one-cycle pulse when a tile has completed.

Function
REQ-015 SHALL implement the FSM states IDLE, RUN and DRAIN.
REQ-016 SHALL, in IDLE with start_i=1, latch pe_mask_i and k_rem_i, clear pe_cnt, and enter RUN next cycle.
REQ-017 SHALL ignore start_i in RUN and DRAIN.
REQ-018 SHALL, in RUN, accept a push beat when push_valid_i and push_ready_o are both high, then increment pe_cnt from 0 to NR_PE-1.
REQ-019 SHALL, when pe_mask[pe_cnt]=0, consume and discard the beat, keeping push_ready_o=1 regardless of pop state.
REQ-020 SHALL, when pe_mask[pe_cnt]=1, enqueue the beat into a 2-entry skid buffer with strb = push_strb_i AND byte mask.
REQ-021 SHALL form the byte mask with bits [k_rem-1:0] set.
REQ-022 SHALL, for kept beats, drive push_ready_o = (buffer not full).
REQ-023 SHALL hold push_ready_o=0 outside RUN.
REQ-024 SHALL deliver a kept beat on pop_* 1 cycle after acceptance (registered output) and sustain 1 beat/cycle when pop_ready_i is held high.
REQ-025 SHALL keep pop_data_o / pop_strb_o stable while pop_valid_o=1 and pop_ready_i=0.
REQ-026 SHALL preserve beat order with no loss or duplication.
REQ-027 SHALL move from RUN to DRAIN when the beat with pe_cnt=NR_PE-1 is accepted.
REQ-028 SHALL, in DRAIN, move to IDLE and pulse done_o in the first cycle the buffer is empty.
REQ-029 SHALL, when the last beat is dropped and the buffer is already empty, still pass through DRAIN for exactly 1 cycle, so done_o fires 2 cycles after that beat.
REQ-030 SHALL, when pe_mask=0, consume all NR_PE beats, produce no pop beats, and still pulse done_o.
REQ-031 SHALL, on clear_i in any state, go to IDLE next cycle, empty the buffer, clear pe_cnt, and produce no done_o pulse.
REQ-032 SHALL give clear_i priority over start_i in the same cycle.

Reset
REQ-033 SHALL, on rst_i, asynchronously force: FSM=IDLE, pe_cnt=0, buffer empty, pop_valid_o=0, pop_data_o=0, pop_strb_o=0, push_ready_o=0, busy_o=0, done_o=0, latched mask=0, latched k_rem=0.
REQ-034 SHALL abort any tile when rst_i is asserted mid-tile, with no done_o pulse.

Configuration
REQ-035 SHALL, with macro NEUREKA_PACKER_PERF_EN defined, add output stall_cnt_o [31:0].
REQ-036 SHALL, under NEUREKA_PACKER_PERF_EN, increment stall_cnt_o each cycle pop_valid_o=1 and pop_ready_i=0, saturate it at 0xFFFFFFFF, and reset it to 0 on start acceptance, rst_i or clear_i.
REQ-037 SHALL, without NEUREKA_PACKER_PERF_EN, omit the port and the counter, with behaviour otherwise identical.

Verification
REQ-038 SHALL verify that pe_mask=9'h1FF, k_rem=0, pop_ready_i=1, 9 back-to-back beats yields 9 pop beats, first one at cycle+1 after acceptance, strb=32'hFFFFFFFF, and done_o 1 cycle after the last pop.
REQ-039 SHALL verify that pe_mask=9'b101010101 with 9 beats yields 5 pop beats in order (PE 0,2,4,6,8), dropped beats consumed without stall, and exactly one done_o.
REQ-040 SHALL verify that k_rem=5 with input strb all-ones yields pop_strb_o=32'h0000001F on every kept beat.
REQ-041 SHALL verify that pop_ready_i=0 for 4 cycles mid-tile gives push_ready_o low after 2 kept beats buffered, pop data stable, no loss after release, and stall_cnt_o=4 under NEUREKA_PACKER_PERF_EN.
REQ-042 SHALL verify that clear_i after 3 accepted beats returns the block to IDLE next cycle with pop_valid_o=0, no done_o, and a following start running a full clean tile.
REQ-043 SHALL verify that rst_i pulsed asynchronously mid-tile immediately forces all outputs to their reset values, and that pe_mask=0 yields 9 beats consumed, 0 pops, and done_o.
